systolic_sequencer: RTL and testbench

Synchronous controller that runs the 4x4 systolic matrix-multiply datapath from an instruction list. Each ap_start runs the list in order. For each instruction it:
- fetches the inner dimension K,
- clears the array,
- streams K columns from the A/B input memories,
- waits for the array pipeline to drain,
- commits the 16 results to the output memory.
All control is on clk posedge; ap_start is sampled, never used as an asynchronous event.

---
 rtl/systolic_pkg.sv | 25 ++
 rtl/systolic_sequencer.sv | 176 +++++++++++++++++
 tb/tb_systolic_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the 4x4 systolic-array sequencer.
// Widths here are defaults; the sequencer re-exposes them as parameters.
package systolic_pkg;

    localparam int ARRAY_DIM         = 4;
    localparam int RESULTS_PER_INSTR = ARRAY_DIM * ARRAY_DIM;
    // Skew across the array plus one cycle of input-memory read latency.
    localparam int DRAIN_CYCLES      = 2 * (ARRAY_DIM - 1) + 1;

    localparam int K_W     = 4;
    localparam int IADDR_W = 3;
    localparam int COL_W   = 8;
    localparam int OADDR_W = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_FEED   = 3'd3,
        S_DRAIN  = 3'd4,
        S_WRITE  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/systolic_sequencer.sv
// Instruction-driven controller for the 4x4 systolic matmul datapath.
// All outputs are registered from the next-state decode, so they line up with the state they belong to.
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter int K_W          = systolic_pkg::K_W,
    parameter int IADDR_W      = systolic_pkg::IADDR_W,
    parameter int COL_W        = systolic_pkg::COL_W,
    parameter int OADDR_W      = systolic_pkg::OADDR_W,
    parameter int DRAIN_CYCLES = systolic_pkg::DRAIN_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ap_start,
    output logic               ap_done,
    output logic               busy,
    output logic               instr_rd_en,
    output logic [IADDR_W-1:0] instr_addr,
    input  logic [K_W-1:0]     instr_data,
    output logic               ab_rd_en,
    output logic [COL_W-1:0]   rd_col,
    output logic               sa_clear,
    output logic               o_wr_en,
    output logic [OADDR_W-1:0] o_base,
    output logic [K_W-1:0]     cur_k,
    output logic               err_ovf
);

    localparam int CNT_W = (K_W > $clog2(DRAIN_CYCLES + 1)) ? K_W : $clog2(DRAIN_CYCLES + 1);
    localparam logic [COL_W:0] COL_LIMIT = {1'b1, {COL_W{1'b0}}};

    state_t             state_r, state_nxt_s;
    logic [IADDR_W-1:0] instr_idx_r, instr_idx_nxt_s;
    logic [COL_W-1:0]   col_ptr_r, col_ptr_nxt_s;
    logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [OADDR_W-1:0] o_base_nxt_s;
    logic [K_W-1:0]     cur_k_nxt_s;
    logic               err_ovf_nxt_s, ap_done_nxt_s;
    logic [COL_W:0]     col_sum_s;
    logic               busy_nxt_s, instr_rd_en_nxt_s, ab_rd_en_nxt_s, o_wr_en_nxt_s;
    logic [IADDR_W-1:0] instr_addr_nxt_s;
    logic [COL_W-1:0]   rd_col_nxt_s;

    // Next-state, counters and sticky status.
    always_comb begin
        state_nxt_s     = state_r;
        instr_idx_nxt_s = instr_idx_r;
        col_ptr_nxt_s   = col_ptr_r;
        cnt_nxt_s       = cnt_r;
        o_base_nxt_s    = o_base;
        cur_k_nxt_s     = cur_k;
        err_ovf_nxt_s   = err_ovf;
        ap_done_nxt_s   = ap_done;
        col_sum_s       = {1'b0, col_ptr_r} + {{(COL_W + 1 - K_W){1'b0}}, instr_data};
        case (state_r)
            S_IDLE, S_DONE: begin
                if (ap_start) begin
                    ap_done_nxt_s   = 1'b0;
                    err_ovf_nxt_s   = 1'b0;
                    instr_idx_nxt_s = '0;
                    col_ptr_nxt_s   = '0;
                    o_base_nxt_s    = '0;
                    state_nxt_s     = S_FETCH;
                end else begin
                    // ap_done trails entry into DONE by one cycle and then holds.
                    ap_done_nxt_s = (state_r == S_DONE);
                end
            end
            S_FETCH: begin
                state_nxt_s = S_DECODE;
            end
            S_DECODE: begin
                cur_k_nxt_s = instr_data;
                if (instr_data == '0) begin
                    state_nxt_s = S_DONE;
                end else if (col_sum_s > COL_LIMIT) begin
                    err_ovf_nxt_s = 1'b1;
                    state_nxt_s   = S_DONE;
                end else begin
                    cnt_nxt_s   = CNT_W'(instr_data);
                    state_nxt_s = S_FEED;
                end
            end
            S_FEED: begin
                col_ptr_nxt_s = col_ptr_r + {{(COL_W - 1){1'b0}}, 1'b1};
                if (cnt_r == CNT_W'(1)) begin
                    cnt_nxt_s   = CNT_W'(DRAIN_CYCLES);
                    state_nxt_s = S_DRAIN;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_r == CNT_W'(1)) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = S_WRITE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            S_WRITE: begin
                o_base_nxt_s    = o_base + OADDR_W'(RESULTS_PER_INSTR);
                instr_idx_nxt_s = instr_idx_r + {{(IADDR_W - 1){1'b0}}, 1'b1};
                if (instr_idx_r == '1) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state; sa_clear shares instr_rd_en's FETCH-only timing.
    always_comb begin
        busy_nxt_s        = 1'b1;
        instr_rd_en_nxt_s = 1'b0;
        instr_addr_nxt_s  = '0;
        ab_rd_en_nxt_s    = 1'b0;
        rd_col_nxt_s      = '0;
        o_wr_en_nxt_s     = 1'b0;
        case (state_nxt_s)
            S_IDLE, S_DONE: busy_nxt_s = 1'b0;
            S_FETCH: begin
                instr_rd_en_nxt_s = 1'b1;
                instr_addr_nxt_s  = instr_idx_nxt_s;
            end
            S_FEED: begin
                ab_rd_en_nxt_s = 1'b1;
                rd_col_nxt_s   = col_ptr_nxt_s;
            end
            S_WRITE: o_wr_en_nxt_s = 1'b1;
            default: busy_nxt_s = 1'b1;
        endcase
    end

    // State, counters and registered outputs; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            instr_idx_r <= '0;
            col_ptr_r   <= '0;
            cnt_r       <= '0;
            o_base      <= '0;
            cur_k       <= '0;
            err_ovf     <= 1'b0;
            ap_done     <= 1'b0;
            busy        <= 1'b0;
            instr_rd_en <= 1'b0;
            instr_addr  <= '0;
            ab_rd_en    <= 1'b0;
            rd_col      <= '0;
            sa_clear    <= 1'b0;
            o_wr_en     <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            instr_idx_r <= instr_idx_nxt_s;
            col_ptr_r   <= col_ptr_nxt_s;
            cnt_r       <= cnt_nxt_s;
            o_base      <= o_base_nxt_s;
            cur_k       <= cur_k_nxt_s;
            err_ovf     <= err_ovf_nxt_s;
            ap_done     <= ap_done_nxt_s;
            busy        <= busy_nxt_s;
            instr_rd_en <= instr_rd_en_nxt_s;
            instr_addr  <= instr_addr_nxt_s;
            ab_rd_en    <= ab_rd_en_nxt_s;
            rd_col      <= rd_col_nxt_s;
            sa_clear    <= instr_rd_en_nxt_s;
            o_wr_en     <= o_wr_en_nxt_s;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: a default instance plus a 5-bit-column
// instance that makes column overflow reachable within eight instructions.
module tb_systolic_sequencer;

    logic       clk = 1'b0;
    logic       rst, ap_start, s_ap_start;
    logic       ap_done, busy, instr_rd_en, ab_rd_en, sa_clear, o_wr_en, err_ovf;
    logic [2:0] instr_addr;
    logic [3:0] instr_data, cur_k;
    logic [7:0] rd_col;
    logic [6:0] o_base;
    logic       s_ap_done, s_busy, s_instr_rd_en, s_ab_rd_en, s_sa_clear, s_o_wr_en, s_err_ovf;
    logic [2:0] s_instr_addr;
    logic [3:0] s_instr_data, s_cur_k;
    logic [4:0] s_rd_col;
    logic [6:0] s_o_base;

    logic [3:0] imem   [8];
    logic [3:0] s_imem [8];
    int col_q[$], base_q[$], addr_q[$], fetch_q[$];
    int cyc = 0, overlap = 0, s_feed_cnt = 0, s_last_col = 0;
    int n_tests = 0, n_fail = 0;
    int lat;

    always #5 clk = ~clk;

    systolic_sequencer dut (
        .clk(clk), .rst(rst), .ap_start(ap_start), .ap_done(ap_done), .busy(busy),
        .instr_rd_en(instr_rd_en), .instr_addr(instr_addr), .instr_data(instr_data),
        .ab_rd_en(ab_rd_en), .rd_col(rd_col), .sa_clear(sa_clear), .o_wr_en(o_wr_en),
        .o_base(o_base), .cur_k(cur_k), .err_ovf(err_ovf)
    );

    systolic_sequencer #(.COL_W(5)) dut_s (
        .clk(clk), .rst(rst), .ap_start(s_ap_start), .ap_done(s_ap_done), .busy(s_busy),
        .instr_rd_en(s_instr_rd_en), .instr_addr(s_instr_addr), .instr_data(s_instr_data),
        .ab_rd_en(s_ab_rd_en), .rd_col(s_rd_col), .sa_clear(s_sa_clear), .o_wr_en(s_o_wr_en),
        .o_base(s_o_base), .cur_k(s_cur_k), .err_ovf(s_err_ovf)
    );

    // Instruction memories with one cycle of read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (instr_rd_en) instr_data <= imem[instr_addr];
        if (s_instr_rd_en) s_instr_data <= s_imem[s_instr_addr];
    end

    // Event recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (ab_rd_en) col_q.push_back(int'(rd_col));
            if (o_wr_en) base_q.push_back(int'(o_base));
            if (instr_rd_en) begin
                addr_q.push_back(int'(instr_addr));
                fetch_q.push_back(cyc);
            end
            if (sa_clear && (ab_rd_en || o_wr_en)) overlap = overlap + 1;
            if (s_sa_clear && (s_ab_rd_en || s_o_wr_en)) overlap = overlap + 1;
            if (s_ab_rd_en) begin
                s_feed_cnt = s_feed_cnt + 1;
                s_last_col = int'(s_rd_col);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        col_q.delete(); base_q.delete(); addr_q.delete(); fetch_q.delete();
        s_feed_cnt = 0;
    endtask

    // Pulse start; lat = edges after the start edge until ap_done is seen (0 = timeout).
    task automatic run_main(output int l);
        ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
        l = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (ap_done) begin l = i; break; end
        end
    endtask

    task automatic run_small(output int l);
        s_ap_start = 1'b1;
        @(posedge clk); #1;
        s_ap_start = 1'b0;
        l = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (s_ap_done) begin l = i; break; end
        end
    endtask

    initial begin
        rst = 1'b1; ap_start = 1'b0; s_ap_start = 1'b0;
        instr_data = 4'd0; s_instr_data = 4'd0;
        for (int i = 0; i < 8; i++) begin imem[i] = 4'd0; s_imem[i] = 4'd0; end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, ap_done, ab_rd_en, rd_col, instr_rd_en, instr_addr,
                              sa_clear, o_wr_en, o_base, cur_k, err_ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // K=2 then terminator
        imem[0] = 4'd2; imem[1] = 4'd0;
        clear_log();
        run_main(lat);
        chk("t1_latency", lat, 32'd15);
        chk("t1_ncols", col_q.size(), 32'd2);
        chk("t1_col0", col_q[0], 32'd0);
        chk("t1_col1", col_q[1], 32'd1);
        chk("t1_nwr", base_q.size(), 32'd1);
        chk("t1_base0", base_q[0], 32'd0);
        chk("t1_addr1", addr_q[1], 32'd1);
        chk("t1_busy", busy, 32'd0);

        // K=3, K=4, terminator
        imem[0] = 4'd3; imem[1] = 4'd4; imem[2] = 4'd0;
        clear_log();
        run_main(lat);
        chk("t2_latency", lat, 32'd30);
        chk("t2_ncols", col_q.size(), 32'd7);
        for (int i = 0; i < 7; i++) chk($sformatf("t2_col%0d", i), col_q[i], i);
        chk("t2_nwr", base_q.size(), 32'd2);
        chk("t2_base1", base_q[1], 32'd16);
        chk("t2_fetch_gap", fetch_q[1] - fetch_q[0], 32'd13);
        chk("t2_cur_k", cur_k, 32'd0);

        // immediate terminator
        imem[0] = 4'd0;
        clear_log();
        run_main(lat);
        chk("t3_latency", lat, 32'd3);
        chk("t3_ncols", col_q.size(), 32'd0);
        chk("t3_nwr", base_q.size(), 32'd0);
        chk("t3_err", err_ovf, 32'd0);

        // eight K=1 instructions, no terminator; then a second identical run
        for (int i = 0; i < 8; i++) imem[i] = 4'd1;
        clear_log();
        run_main(lat);
        chk("t4_latency", lat, 32'd89);
        chk("t4_nwr", base_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("t4_base%0d", i), base_q[i], 32'(16 * i));
        chk("t4_col7", col_q[7], 32'd7);
        chk("t4_base_wrap", o_base, 32'd0);
        clear_log();
        run_main(lat);
        chk("t4_rerun_latency", lat, 32'd89);
        chk("t4_rerun_col0", col_q[0], 32'd0);
        chk("t4_rerun_base0", base_q[0], 32'd0);

        // 32-column instance: exact fill is legal, one past aborts
        s_imem[0] = 4'd15; s_imem[1] = 4'd15; s_imem[2] = 4'd2; s_imem[3] = 4'd0;
        clear_log();
        run_small(lat);
        chk("t5_fill_latency", lat, 32'd65);
        chk("t5_fill_feeds", s_feed_cnt, 32'd32);
        chk("t5_fill_lastcol", s_last_col, 32'd31);
        chk("t5_fill_base", s_o_base, 32'd48);
        chk("t5_fill_err", s_err_ovf, 32'd0);
        s_imem[2] = 4'd3;
        clear_log();
        run_small(lat);
        chk("t5_ovf_latency", lat, 32'd53);
        chk("t5_ovf_feeds", s_feed_cnt, 32'd30);
        chk("t5_ovf_err", s_err_ovf, 32'd1);
        chk("t5_ovf_cur_k", s_cur_k, 32'd3);
        chk("t5_ovf_busy", s_busy, 32'd0);
        s_imem[0] = 4'd0;
        run_small(lat);
        chk("t5_clear_latency", lat, 32'd3);
        chk("t5_err_cleared", s_err_ovf, 32'd0);

        // reset in the middle of a K=5 feed, after an ignored start pulse
        imem[0] = 4'd1; imem[1] = 4'd5; imem[2] = 4'd0;
        clear_log();
        ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (ab_rd_en && cur_k == 4'd5) begin lat = i; break; end
        end
        chk("t6_reach_feed", lat, 32'd13);
        chk("t6_feed_col", rd_col, 32'd1);
        ap_start = 1'b1;
        @(posedge clk); #1;
        ap_start = 1'b0;
        chk("t6_start_ignored_feed", ab_rd_en, 32'd1);
        chk("t6_start_ignored_col", rd_col, 32'd2);
        chk("t6_start_ignored_fetch", instr_rd_en, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_reset_outputs", {busy, ap_done, ab_rd_en, rd_col, instr_rd_en, instr_addr,
                                 sa_clear, o_wr_en, o_base, cur_k, err_ovf}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t6_idle_busy", busy, 32'd0);
        clear_log();
        run_main(lat);
        chk("t6_rerun_latency", lat, 32'd29);
        chk("t6_rerun_addr0", addr_q[0], 32'd0);
        chk("t6_rerun_col0", col_q[0], 32'd0);
        chk("t6_rerun_ncols", col_q.size(), 32'd6);

        chk("clear_exclusive", overlap, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
